// File: rtl/bcd_entry.sv
// bcd_entry: two-digit BCD keypad entry with load edge detection, error state and registered binary value.
module bcd_entry (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit,
    input  logic       load,
    input  logic       clear,
    output logic [6:0] value,
    output logic       valid,
    output logic       err,
    output logic [1:0] count
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO, ERR} state_t;

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d, ones_q, ones_d;
    logic [1:0] count_q, count_d;
    logic [6:0] value_q, conv;
    logic       load_q, valid_q, err_q, accept, ok, write;

    always_comb begin
        accept  = load & ~load_q;
        ok      = digit <= 4'd9;
        write   = accept && ok && state_q != ERR && !clear;
        state_d = clear ? EMPTY :
                  (!accept || state_q == ERR) ? state_q :
                  !ok ? ERR :
                  (state_q == EMPTY) ? ONE : TWO;
        tens_d  = clear ? 4'd0 : write ? ((state_q == EMPTY) ? 4'd0 : ones_q) : tens_q;
        ones_d  = clear ? 4'd0 : write ? digit : ones_q;
        // ERR keeps the digit count of the state it was entered from
        count_d = (state_d == ONE) ? 2'd1 :
                  (state_d == TWO) ? 2'd2 :
                  (state_d == ERR) ? count_q : 2'd0;
        conv    = {tens_q, 3'b000} + {2'b00, tens_q, 1'b0} + {3'b000, ones_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            load_q  <= 1'b1;
            count_q <= 2'd0;
            value_q <= 7'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            load_q  <= load;
            count_q <= count_d;
            value_q <= (state_q == ERR) ? value_q : conv;
            valid_q <= (state_q == ERR) ? valid_q : (state_q == ONE || state_q == TWO);
            err_q   <= state_d == ERR;
        end
    end

    assign value = value_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign count = count_q;
endmodule

// File: tb/tb_bcd_entry.sv
// tb_bcd_entry: directed checks of digit entry, edge detection, error handling, clear and async reset.
module tb_bcd_entry;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit = 4'd0;
    logic       load = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] value;
    logic       valid, err;
    logic [1:0] count;
    int         n_tests = 0;
    int         n_fail = 0;

    bcd_entry dut (
        .clk(clk), .reset(reset), .digit(digit), .load(load), .clear(clear),
        .value(value), .valid(valid), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [6:0] v, input logic vl, input logic e, input logic [1:0] c);
        check({tag, ".value"}, {1'b0, value}, {1'b0, v});
        check({tag, ".valid"}, {7'd0, valid}, {7'd0, vl});
        check({tag, ".err"}, {7'd0, err}, {7'd0, e});
        check({tag, ".count"}, {6'd0, count}, {6'd0, c});
    endtask

    // leaves at the negedge after the accept edge; value updates one edge later
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        digit = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #1;
        outs("reset", 7'd0, 1'b0, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        press(4'd4);
        outs("d4_edge", 7'd0, 1'b0, 1'b0, 2'd1);
        @(negedge clk);
        outs("d4_val", 7'd4, 1'b1, 1'b0, 2'd1);
        press(4'd7);
        outs("d47_edge", 7'd4, 1'b1, 1'b0, 2'd2);
        @(negedge clk);
        outs("d47_val", 7'd47, 1'b1, 1'b0, 2'd2);

        do_clear();
        press(4'd1);
        press(4'd2);
        @(negedge clk);
        digit = 4'd3;
        load = 1'b1;
        repeat (5) @(negedge clk);
        digit = 4'd8;
        repeat (5) @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        outs("d123_hold", 7'd23, 1'b1, 1'b0, 2'd2);

        do_clear();
        press(4'd5);
        @(negedge clk);
        outs("d5_val", 7'd5, 1'b1, 1'b0, 2'd1);
        press(4'd12);
        outs("err_enter", 7'd5, 1'b1, 1'b1, 2'd1);
        press(4'd6);
        @(negedge clk);
        outs("err_ignore", 7'd5, 1'b1, 1'b1, 2'd1);
        do_clear();
        check("err_clr.err", {7'd0, err}, 8'd0);
        check("err_clr.count", {6'd0, count}, 8'd0);
        @(negedge clk);
        outs("err_clr_next", 7'd0, 1'b0, 1'b0, 2'd0);

        press(4'd3);
        @(negedge clk);
        digit = 4'd9;
        load = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        load = 1'b0;
        clear = 1'b0;
        check("clr_win.count", {6'd0, count}, 8'd0);
        @(negedge clk);
        outs("clr_win_next", 7'd0, 1'b0, 1'b0, 2'd0);
        press(4'd9);
        @(negedge clk);
        outs("after_clr_9", 7'd9, 1'b1, 1'b0, 2'd1);

        do_clear();
        press(4'd9);
        press(4'd9);
        @(negedge clk);
        outs("d99", 7'd99, 1'b1, 1'b0, 2'd2);
        #2;
        reset = 1'b1;
        #1;
        outs("async_rst", 7'd0, 1'b0, 1'b0, 2'd0);

        load = 1'b1;
        digit = 4'd6;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        outs("held_load", 7'd0, 1'b0, 1'b0, 2'd0);
        load = 1'b0;
        press(4'd6);
        @(negedge clk);
        outs("reload", 7'd6, 1'b1, 1'b0, 2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
